// File: rtl/piso_en_serializer.sv
// Parallel-in/serial-out stage that feeds an enabled D flip-flop. It accepts one
// word over a valid/ready handshake. Each bit is held on ser_d for DIV clocks,
// and ser_en pulses in the last cycle of every bit period.
module piso_en_serializer #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_d,
  output logic             ser_en,
  output logic             busy,
  output logic             done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH);
  // Value of div_cnt one cycle before the strobe cycle. It only matters for DIV >= 2.
  localparam logic [CW-1:0] DIV_PRE  = CW'((DIV >= 2) ? DIV - 2 : 0);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_PRE  = BW'(WIDTH - 2);
  // With DIV=1 every cycle of a word is a strobe cycle.
  localparam bit EN_EVERY = (DIV == 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CW-1:0]    div_cnt, div_nxt;
  logic [BW-1:0]    bit_cnt, bit_nxt;
  logic             ready_nxt, d_nxt, en_nxt, busy_nxt, done_nxt;

  // Bit presented at the output end of the shift register.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST != 0) first_bit = w[WIDTH-1];
    else                first_bit = w[0];
  endfunction

  // Move the register one place toward the output end, filling with zero.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    if (MSB_FIRST != 0) shift_word = {w[WIDTH-2:0], 1'b0};
    else                shift_word = {1'b0, w[WIDTH-1:1]};
  endfunction

  // Next state and next registered outputs. All outputs come from flops, so
  // each one is computed one cycle ahead of the cycle in which it appears.
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    ready_nxt = 1'b0;
    d_nxt     = 1'b0;
    en_nxt    = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        ready_nxt = 1'b1;
        if (load_valid && load_ready) begin
          state_nxt = SHIFT;
          sreg_nxt  = load_data;
          div_nxt   = '0;
          bit_nxt   = '0;
          ready_nxt = 1'b0;
          busy_nxt  = 1'b1;
          d_nxt     = first_bit(load_data);
          en_nxt    = EN_EVERY;
        end
      end
      SHIFT: begin
        busy_nxt = 1'b1;
        if (ser_en) begin
          if (bit_cnt == BIT_LAST) begin
            // The final strobe has been issued, so the word is complete.
            state_nxt = IDLE;
            sreg_nxt  = '0;
            div_nxt   = '0;
            bit_nxt   = '0;
            ready_nxt = 1'b1;
            busy_nxt  = 1'b0;
          end else begin
            sreg_nxt = shift_word(sreg);
            div_nxt  = '0;
            bit_nxt  = bit_cnt + BW'(1);
            d_nxt    = first_bit(shift_word(sreg));
            en_nxt   = EN_EVERY;
            done_nxt = EN_EVERY && (bit_cnt == BIT_PRE);
          end
        end else begin
          div_nxt  = div_cnt + CW'(1);
          d_nxt    = ser_d;
          en_nxt   = (div_cnt == DIV_PRE);
          done_nxt = (div_cnt == DIV_PRE) && (bit_cnt == BIT_LAST);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and output registers; all of them clear asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sreg       <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      load_ready <= 1'b0;
      ser_d      <= 1'b0;
      ser_en     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      sreg       <= sreg_nxt;
      div_cnt    <= div_nxt;
      bit_cnt    <= bit_nxt;
      load_ready <= ready_nxt;
      ser_d      <= d_nxt;
      ser_en     <= en_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_piso_en_serializer.sv
// Bench for piso_en_serializer. It uses three configurations: DIV=4 MSB-first,
// DIV=4 LSB-first and DIV=1 MSB-first. A cycle-indexed reference model checks
// every output. A downstream enabled flop and a collector register check the
// end-to-end data.
module tb_piso_en_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       lv [3];
  logic [7:0] ld [3];
  logic       lr [3];
  logic       sd [3];
  logic       se [3];
  logic       bz [3];
  logic       dn [3];

  int dv [3];
  bit ms [3];

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  piso_en_serializer #(.WIDTH(8), .DIV(4), .MSB_FIRST(1)) u_msb4 (
    .clk(clk), .reset(reset), .load_valid(lv[0]), .load_data(ld[0]),
    .load_ready(lr[0]), .ser_d(sd[0]), .ser_en(se[0]), .busy(bz[0]), .done(dn[0]));

  piso_en_serializer #(.WIDTH(8), .DIV(4), .MSB_FIRST(0)) u_lsb4 (
    .clk(clk), .reset(reset), .load_valid(lv[1]), .load_data(ld[1]),
    .load_ready(lr[1]), .ser_d(sd[1]), .ser_en(se[1]), .busy(bz[1]), .done(dn[1]));

  piso_en_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1)) u_msb1 (
    .clk(clk), .reset(reset), .load_valid(lv[2]), .load_data(ld[2]),
    .load_ready(lr[2]), .ser_d(sd[2]), .ser_en(se[2]), .busy(bz[2]), .done(dn[2]));

  // Downstream enabled flop plus a collector that takes q one cycle after each strobe.
  logic       ff_q, en_d;
  logic [7:0] collect;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff_q    <= 1'b0;
      en_d    <= 1'b0;
      collect <= '0;
    end else begin
      if (se[0]) ff_q <= sd[0];
      en_d <= se[0];
      if (en_d) collect <= {collect[6:0], ff_q};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {load_ready, busy, ser_d, ser_en, done} in cycle c after the handshake edge.
  function automatic logic [4:0] model(input logic [7:0] w, input int c, input int d, input bit msb);
    int   n;
    int   k;
    logic b;
    n = 8 * d;
    if (c > n) return 5'b10000;
    k = (c - 1) / d;
    b = msb ? w[7 - k] : w[k];
    return {1'b0, 1'b1, b, (c % d) == 0, c == n};
  endfunction

  function automatic logic [4:0] obs(input int i);
    return {lr[i], bz[i], sd[i], se[i], dn[i]};
  endfunction

  // Hand one word to instance i and check every cycle of it.
  // hold: keep load_valid high with nxt presented during the word.
  // abort_at: cycle at which reset is asserted (0 means never).
  task automatic run_word(input int i, input logic [7:0] w, input bit hold,
                          input logic [7:0] nxt, input int abort_at);
    int n;
    int cnt;
    n = 8 * dv[i];
    cnt = 0;
    while (!lr[i] && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    if (!lr[i]) begin
      chk($sformatf("ready_timeout_i%0d", i), 32'(lr[i]), 32'd1);
      return;
    end
    lv[i] = 1'b1;
    ld[i] = w;
    @(posedge clk);
    #1;
    if (hold) ld[i] = nxt;
    else begin
      lv[i] = 1'($urandom_range(0, 1));
      ld[i] = 8'($urandom);
    end
    for (int c = 1; c <= n + 1; c++) begin
      @(negedge clk);
      chk($sformatf("i%0d_w%0h_c%0d", i, w, c), 32'(obs(i)), 32'(model(w, c, dv[i], ms[i])));
      if (c == abort_at) begin
        reset = 1'b1;
        lv[i] = 1'b0;
        #1;
        chk($sformatf("async_rst_i%0d", i), 32'(obs(i)), 32'd0);
        for (int r = 0; r < 3; r++) begin
          @(negedge clk);
          chk($sformatf("in_rst_i%0d_%0d", i, r), 32'(obs(i)), 32'd0);
        end
        reset = 1'b0;
        return;
      end
      if (!hold) begin
        if (c < n) lv[i] = 1'($urandom_range(0, 1));
        else       lv[i] = 1'b0;
      end
    end
  endtask

  initial begin
    dv[0] = 4; ms[0] = 1'b1;
    dv[1] = 4; ms[1] = 1'b0;
    dv[2] = 1; ms[2] = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lv[i] = 1'b0;
      ld[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("reset_state_i%0d", i), 32'(obs(i)), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("ready_after_rst_i%0d", i), 32'(obs(i)), 32'b10000);

    // Directed words
    run_word(0, 8'hA5, 1'b0, 8'h00, 0);
    run_word(1, 8'h01, 1'b0, 8'h00, 0);
    run_word(2, 8'hF0, 1'b0, 8'h00, 0);

    // Valid held high through a word; second word taken when ready returns
    run_word(0, 8'h3C, 1'b1, 8'hC3, 0);
    run_word(0, 8'hC3, 1'b0, 8'h00, 0);

    // Reset in the middle of a word, then a fresh word
    run_word(0, 8'h96, 1'b0, 8'h00, 13);
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("ready_after_abort_i%0d", i), 32'(obs(i)), 32'b10000);
    run_word(0, 8'hFF, 1'b0, 8'h00, 0);

    // End to end through the downstream flop
    run_word(0, 8'h5A, 1'b0, 8'h00, 0);
    @(negedge clk);
    chk("collect_5a", 32'(collect), 32'h5A);

    // Random words on every configuration
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 3; i++)
        run_word(i, 8'($urandom), 1'b0, 8'h00, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
